// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch sequencer that owns the program counter.
// It boots the external PC register to RESET_PC and fetches the word at the
// current PC over a req/ack handshake. It then hands the word to the core,
// waits for the core to retire it, and chooses the next PC. The next PC is
// the sequential address, the branch target, or the trap vector. The
// sequencer also keeps the trap PC (epc), the trap cause and a retired-
// instruction counter.
//
// Fetch handshake: fetch_req is held high for every cycle spent in FETCH,
// with fetch_addr stable (it is pc_q, and the PC register does not load in
// FETCH). A transfer happens in the first cycle where fetch_req && fetch_ack.
// fetch_data is captured in that same cycle, and fetch_req drops in the
// following cycle. fetch_ack is ignored whenever fetch_req is low.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_next,
  output logic        pc_ena,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] inst_q,
  output logic        inst_valid,
  input  logic        done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap,
  input  logic        stall,
  output logic [31:0] epc,
  output logic        cause,
  output logic [31:0] instret,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] next_q;
  logic        trap_q;

  logic [31:0] dec_pc;
  logic        dec_trap;
  logic        dec_cause;

  logic        fetch_xfer;
  logic        retire;
  logic        decide;

  // A fetch transfers, a decision is taken, and a PC update commits only in
  // their owning states. This is what makes the inputs ignored elsewhere.
  assign fetch_xfer = (state == FETCH)  && fetch_ack;
  assign decide     = (state == ISSUE)  && done;
  assign retire     = (state == UPDATE) && !stall;

  assign dbg_state  = state;
  assign fetch_addr = pc_q;

  // State register; reset always returns to BOOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and PC-register / fetch controls.
  always_comb begin
    state_nx  = state;
    pc_next   = next_q;
    pc_ena    = 1'b0;
    fetch_req = 1'b0;
    case (state)
      BOOT: begin
        pc_next  = RESET_PC;
        pc_ena   = 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (done) begin
          state_nx = UPDATE;
        end
      end
      UPDATE: begin
        if (!stall) begin
          pc_ena   = 1'b1;
          state_nx = FETCH;
        end
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  // Next-PC choice for the retiring instruction. The priority order is:
  // trap, misaligned taken branch, taken branch, then sequential.
  always_comb begin
    dec_pc    = pc_q + PC_INC;
    dec_trap  = 1'b0;
    dec_cause = 1'b0;
    if (trap) begin
      dec_pc    = TRAP_VEC;
      dec_trap  = 1'b1;
      dec_cause = 1'b0;
    end else if (br_taken && (br_target[1:0] != 2'b00)) begin
      dec_pc    = TRAP_VEC;
      dec_trap  = 1'b1;
      dec_cause = 1'b1;
    end else if (br_taken) begin
      dec_pc    = br_target;
    end
  end

  // Instruction latch and its one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q     <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= fetch_xfer;
      if (fetch_xfer) begin
        inst_q <= fetch_data;
      end
    end
  end

  // Registered next-PC decision, trap flag, and trap bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_q <= RESET_PC;
      trap_q <= 1'b0;
      epc    <= 32'd0;
      cause  <= 1'b0;
    end else if (decide) begin
      next_q <= dec_pc;
      trap_q <= dec_trap;
      if (dec_trap) begin
        epc   <= pc_q;
        cause <= dec_cause;
      end
    end
  end

  // Retired-instruction counter: it counts committed non-trap decisions only.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 32'd0;
    end else if (retire && !trap_q) begin
      instret <= instret + 32'd1;
    end
  end

endmodule
